// File: rtl/accumulator_pkg.sv
// Shared types and constants for the accumulator self-test load driver.
package accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND        = 2'd1,
        WAIT_RESULT = 2'd2,
        DONE        = 2'd3
    } state_e;

    localparam logic [31:0] LFSR_MASK          = 32'h8020_0003;
    localparam int          LOAD_WIDTH         = 16;
    localparam int          DEFAULT_DATA_WIDTH = 32;

    // Right-shifting Galois step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'd0);
    endfunction

endpackage

// File: rtl/load_lfsr.sv
// 32-bit Galois LFSR word source; the low 16 bits of the state form the word.
module load_lfsr
    import accumulator_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0087_8A83
) (
    input  logic                  bus_clk,
    input  logic                  reset_n,
    input  logic                  seed_load,
    input  logic                  advance,
    output logic [LOAD_WIDTH-1:0] word
);

    // An all-zero state would lock up the register, so it is replaced by 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] state_q;

    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEED_EFF;
        end else if (seed_load) begin
            state_q <= SEED_EFF;
        end else if (advance) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign word = state_q[LOAD_WIDTH-1:0];

endmodule

// File: rtl/accumulator_load_driver.sv
// Streams a burst of 16-bit words into the accumulator, tracks their sum and
// grades the accumulator's reported result as pass, fail or timeout.
module accumulator_load_driver
    import accumulator_pkg::*;
#(
    parameter int          WORD_COUNT     = 1024,
    parameter int          DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int          PATTERN        = 0,
    parameter logic [31:0] LFSR_SEED      = 32'h0087_8A83,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic                  bus_clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  result_valid,
    output logic [DATA_WIDTH-1:0] load,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [DATA_WIDTH-1:0] expected_sum
);

    state_e                  state_q;
    logic [31:0]             word_cnt_q;
    logic [31:0]             wait_cnt_q;
    logic [DATA_WIDTH-1:0]   load_q;
    logic [DATA_WIDTH-1:0]   sum_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic                    timeout_q;

    logic                    seed_load;
    logic                    advance;
    logic [LOAD_WIDTH-1:0]   lfsr_word;
    logic [LOAD_WIDTH-1:0]   cur_word;

    assign seed_load = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign advance   = (state_q == SEND);
    assign cur_word  = (PATTERN == 1) ? word_cnt_q[LOAD_WIDTH-1:0] : lfsr_word;

    load_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .bus_clk   (bus_clk),
        .reset_n   (reset_n),
        .seed_load (seed_load),
        .advance   (advance),
        .word      (lfsr_word)
    );

    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            wait_cnt_q <= '0;
            load_q     <= '0;
            sum_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= SEND;
                        word_cnt_q <= '0;
                        sum_q      <= '0;
                        load_q     <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                    end
                end
                SEND: begin
                    load_q     <= DATA_WIDTH'(cur_word);
                    sum_q      <= sum_q + DATA_WIDTH'(cur_word);
                    word_cnt_q <= word_cnt_q + 32'd1;
                    // The last word leaves on the same edge that enters WAIT_RESULT.
                    if (word_cnt_q == 32'(WORD_COUNT - 1)) begin
                        state_q    <= WAIT_RESULT;
                        wait_cnt_q <= '0;
                    end
                end
                WAIT_RESULT: begin
                    load_q     <= '0;
                    wait_cnt_q <= wait_cnt_q + 32'd1;
                    if (result_valid) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= (result == sum_q);
                        timeout_q <= 1'b0;
                    end else if (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign load         = load_q;
    assign expected_sum = sum_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_accumulator_load_driver.sv
// Randomised self-checking bench for accumulator_load_driver across three configurations.
module tb_accumulator_load_driver;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i [3];
    logic        rv_i    [3];
    logic [31:0] result_i[3];
    logic [31:0] load_w  [3];
    logic [31:0] sum_w   [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic        pass_w  [3];
    logic        to_w    [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accumulator_load_driver #(.WORD_COUNT(3), .PATTERN(0), .LFSR_SEED(32'h1), .TIMEOUT_CYCLES(T)) u_lfsr3 (
        .bus_clk(clk), .reset_n(reset_n), .start(start_i[0]), .result(result_i[0]),
        .result_valid(rv_i[0]), .load(load_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .timeout(to_w[0]), .expected_sum(sum_w[0]));

    accumulator_load_driver #(.WORD_COUNT(1024), .PATTERN(1), .TIMEOUT_CYCLES(T)) u_inc (
        .bus_clk(clk), .reset_n(reset_n), .start(start_i[1]), .result(result_i[1]),
        .result_valid(rv_i[1]), .load(load_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .timeout(to_w[1]), .expected_sum(sum_w[1]));

    accumulator_load_driver #(.WORD_COUNT(200), .PATTERN(0), .TIMEOUT_CYCLES(T)) u_lfsr200 (
        .bus_clk(clk), .reset_n(reset_n), .start(start_i[2]), .result(result_i[2]),
        .result_valid(rv_i[2]), .load(load_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .timeout(to_w[2]), .expected_sum(sum_w[2]));

    function automatic int wc_of(input int idx);
        return (idx == 0) ? 3 : (idx == 1) ? 1024 : 200;
    endfunction

    // Reference word list straight from the pattern definition.
    function automatic void build_words(input int idx, output logic [15:0] w[$]);
        logic [31:0] s;
        s = (idx == 0) ? 32'h1 : 32'h0087_8A83;
        w = {};
        for (int k = 0; k < wc_of(idx); k++) begin
            if (idx == 1) w.push_back(16'(k % 65536));
            else          w.push_back(s[15:0]);
            s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_i[i] = 1'b0; rv_i[i] = 1'b0; result_i[i] = '0;
        end
        step(); step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (load_w[i] !== 0 || sum_w[i] !== 0 || busy_w[i] !== 0 || done_w[i] !== 0 ||
                pass_w[i] !== 0 || to_w[i] !== 0) begin
                errors++;
                $display("FAIL reset idx=%0d load=%0d sum=%0d busy=%b done=%b pass=%b timeout=%b want all 0",
                         i, load_w[i], sum_w[i], busy_w[i], done_w[i], pass_w[i], to_w[i]);
            end
        end
        reset_n = 1'b1;
        step();
        $display("reset: all instances idle");
    endtask

    // d: wait cycle on which result_valid is raised (d >= T means never).
    task automatic run_case(input int idx, input int d, input bit corrupt, input bit junk, input string tag);
        logic [15:0] words[$];
        logic [31:0] exp_sum;
        int          wc;
        int          jd;
        bit          exp_pass;
        bit          exp_to;
        build_words(idx, words);
        wc = wc_of(idx);
        exp_sum = 32'd0;
        foreach (words[k]) exp_sum = exp_sum + 32'(words[k]);
        jd       = (d < T) ? d : T - 1;
        exp_to   = (d >= T);
        exp_pass = (d < T) && !corrupt;

        start_i[idx] = 1'b1;
        step();
        start_i[idx] = 1'b0;
        checks++;
        if (busy_w[idx] !== 1 || done_w[idx] !== 0 || pass_w[idx] !== 0 || to_w[idx] !== 0 ||
            sum_w[idx] !== 0 || load_w[idx] !== 0) begin
            errors++;
            $display("FAIL %s start busy=%b done=%b pass=%b timeout=%b sum=%0d load=%0d want 1 0 0 0 0 0",
                     tag, busy_w[idx], done_w[idx], pass_w[idx], to_w[idx], sum_w[idx], load_w[idx]);
        end

        begin
            logic [31:0] part;
            part = 32'd0;
            for (int k = 0; k < wc; k++) begin
                if (junk) begin
                    start_i[idx]  = 1'($urandom_range(0, 1));
                    rv_i[idx]     = 1'($urandom_range(0, 1));
                    result_i[idx] = $urandom;
                end
                step();
                part = part + 32'(words[k]);
                checks++;
                if (load_w[idx] !== 32'(words[k]) || sum_w[idx] !== part || busy_w[idx] !== 1 ||
                    done_w[idx] !== 0) begin
                    errors++;
                    $display("FAIL %s word%0d load=%0d sum=%0d busy=%b done=%b want load=%0d sum=%0d busy=1 done=0",
                             tag, k, load_w[idx], sum_w[idx], busy_w[idx], done_w[idx], words[k], part);
                end
            end
        end
        start_i[idx] = 1'b0;
        rv_i[idx]    = 1'b0;

        for (int j = 0; j <= jd; j++) begin
            checks++;
            if (done_w[idx] !== 0 || busy_w[idx] !== 1 ||
                load_w[idx] !== ((j == 0) ? 32'(words[wc-1]) : 32'd0)) begin
                errors++;
                $display("FAIL %s wait%0d done=%b busy=%b load=%0d want done=0 busy=1 load=%0d",
                         tag, j, done_w[idx], busy_w[idx], load_w[idx], (j == 0) ? words[wc-1] : 16'd0);
            end
            if (j == d) begin
                rv_i[idx]     = 1'b1;
                result_i[idx] = corrupt ? exp_sum - 32'd1 : exp_sum;
            end else begin
                rv_i[idx]     = 1'b0;
                result_i[idx] = $urandom;
            end
            step();
        end
        rv_i[idx] = 1'b0;

        checks++;
        if (done_w[idx] !== 1 || busy_w[idx] !== 0 || pass_w[idx] !== exp_pass || to_w[idx] !== exp_to ||
            load_w[idx] !== 0 || sum_w[idx] !== exp_sum) begin
            errors++;
            $display("FAIL %s final done=%b busy=%b pass=%b timeout=%b load=%0d sum=%0d want 1 0 %b %b 0 %0d",
                     tag, done_w[idx], busy_w[idx], pass_w[idx], to_w[idx], load_w[idx], sum_w[idx],
                     exp_pass, exp_to, exp_sum);
        end

        // result_valid is ignored in DONE; everything must hold.
        for (int h = 0; h < 3; h++) begin
            rv_i[idx]     = 1'($urandom_range(0, 1));
            result_i[idx] = $urandom;
            step();
            checks++;
            if (done_w[idx] !== 1 || pass_w[idx] !== exp_pass || to_w[idx] !== exp_to ||
                sum_w[idx] !== exp_sum || load_w[idx] !== 0) begin
                errors++;
                $display("FAIL %s hold%0d done=%b pass=%b timeout=%b sum=%0d load=%0d want 1 %b %b %0d 0",
                         tag, h, done_w[idx], pass_w[idx], to_w[idx], sum_w[idx], load_w[idx],
                         exp_pass, exp_to, exp_sum);
            end
        end
        rv_i[idx] = 1'b0;
        $display("run %s idx=%0d words=%0d rv_at=%0d corrupt=%0b sum=%0d pass=%0b timeout=%0b",
                 tag, idx, wc, d, corrupt, exp_sum, exp_pass, exp_to);
    endtask

    task automatic test_reset_mid_send();
        start_i[1] = 1'b1;
        step();
        start_i[1] = 1'b0;
        repeat (101) step();
        checks++;
        if (load_w[1] !== 32'd100) begin
            errors++;
            $display("FAIL midsend load=%0d want 100", load_w[1]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (load_w[1] !== 0 || sum_w[1] !== 0 || busy_w[1] !== 0 || done_w[1] !== 0 ||
            pass_w[1] !== 0 || to_w[1] !== 0) begin
            errors++;
            $display("FAIL async_reset load=%0d sum=%0d busy=%b done=%b pass=%b timeout=%b want all 0",
                     load_w[1], sum_w[1], busy_w[1], done_w[1], pass_w[1], to_w[1]);
        end
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (busy_w[1] !== 0 || load_w[1] !== 0 || done_w[1] !== 0) begin
            errors++;
            $display("FAIL post_reset busy=%b load=%0d done=%b want 0 0 0", busy_w[1], load_w[1], done_w[1]);
        end
        $display("reset mid-send after word 100");
        run_case(1, 2, 1'b0, 1'b0, "restart_after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int idx;
            idx = ($urandom_range(0, 1) == 1) ? 2 : 0;
            run_case(idx, $urandom_range(0, 20), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        run_case(0, 0, 1'b0, 1'b0, "lfsr_seq");
        run_case(1, 0, 1'b0, 1'b0, "incrementing");
        run_case(1, 3, 1'b1, 1'b0, "mismatch");
        run_case(0, 100, 1'b0, 1'b0, "timeout");
        run_case(0, T - 1, 1'b0, 1'b0, "tie_pass");
        run_case(0, T - 1, 1'b1, 1'b0, "tie_fail");
        run_case(2, 5, 1'b0, 1'b1, "ignored_inputs");
        run_case(2, 5, 1'b0, 1'b0, "rerun_from_done");
        test_reset_mid_send();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
